// File: rtl/cmos_frame_writer_pkg.sv
// cmos_pkg: shared types, default geometry and counter-width helpers for
// the CMOS frame writer slice.
package cmos_pkg;

    // Frame writer FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2,
        DROP     = 2'd3
    } cmos_state_e;

    // Default geometry and pixel width
    localparam int H_DISP_DEF = 640;
    localparam int V_DISP_DEF = 480;
    localparam int DW_DEF     = 16;

    // Width of the pixel-in-line counter: must hold the value H_DISP
    function automatic int x_cnt_w(input int h_disp);
        return (h_disp < 1) ? 1 : $clog2(h_disp + 1);
    endfunction

    // Width of the line-in-frame counter: must hold the value V_DISP
    function automatic int y_cnt_w(input int v_disp);
        return (v_disp < 1) ? 1 : $clog2(v_disp + 1);
    endfunction

endpackage

// File: rtl/cmos_frame_writer_if.sv
// SDRAM write-FIFO side of the CMOS frame writer: write strobe, data,
// base-address reload pulse and the FIFO full back-pressure flag.
interface cmos_frame_writer_if
    import cmos_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          oWR_EN;
    logic [DW-1:0] oWR_DATA;
    logic          oWR_LOAD;
    logic          iWR_FULL;

    modport master (
        output oWR_EN,
        output oWR_DATA,
        output oWR_LOAD,
        input  iWR_FULL
    );

    modport slave (
        input  oWR_EN,
        input  oWR_DATA,
        input  oWR_LOAD,
        output iWR_FULL
    );
endinterface

// File: rtl/cmos_frame_writer_fps_meter.sv
// cmos_fps_meter: counts good-frame pulses over a one-second window of
// CLK_HZ cycles and publishes the count (saturated at 255) at window end.
module cmos_fps_meter #(
    parameter int CLK_HZ = 24_000_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iFRAME_DONE,
    output logic [7:0] oFPS
);
    localparam int WW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [WW-1:0] WIN_END = WW'(CLK_HZ - 1);

    logic [WW-1:0] win_r;
    logic [7:0]    cnt_r;
    logic [7:0]    cnt_inc_s;

    // Saturating frame count including this cycle's pulse
    always_comb begin
        if (iFRAME_DONE && (cnt_r != 8'hFF)) begin
            cnt_inc_s = cnt_r + 8'd1;
        end else begin
            cnt_inc_s = cnt_r;
        end
    end

    // One-second window: publish the count at the last cycle and restart
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            win_r <= {WW{1'b0}};
            cnt_r <= 8'd0;
            oFPS  <= 8'd0;
        end else if (win_r == WIN_END) begin
            win_r <= {WW{1'b0}};
            cnt_r <= 8'd0;
            oFPS  <= cnt_inc_s;
        end else begin
            win_r <= win_r + WW'(1);
            cnt_r <= cnt_inc_s;
        end
    end
endmodule

// File: rtl/cmos_frame_writer.sv
// cmos_frame_writer: forwards only complete, aligned RGB565 frames from the
// CMOS capture stream into the SDRAM write FIFO. Counts X/Y against the
// configured geometry, flags short/long lines, bad frames and FIFO overflow.
// Optional FPS meter is built when CMOS_FPS_EN is defined.
module cmos_frame_writer
    import cmos_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int V_DISP = V_DISP_DEF,
    parameter int DW     = DW_DEF,
    parameter int CLK_HZ = 24_000_000
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [DW-1:0]       iPIX_DATA,
    input  logic                iPIX_VLD,
    input  logic                iHREF,
    input  logic                iFRAME_VLD,
    input  logic                iERR_CLR,
    cmos_frame_writer_if.master wr,
    output logic                oFRAME_DONE,
    output logic                oFRAME_ERR,
    output logic                oLINE_ERR,
    output logic                oOVF,
    output logic [7:0]          oFPS
);
    localparam int XW = x_cnt_w(H_DISP);
    localparam int YW = y_cnt_w(V_DISP);
    localparam logic [XW-1:0] X_MAX = XW'(H_DISP);
    localparam logic [YW-1:0] Y_MAX = YW'(V_DISP);

    cmos_state_e   state_r;
    logic          href_r;
    logic          fvld_r;
    logic [XW-1:0] x_cnt_r;
    logic [YW-1:0] y_cnt_r;
    logic          line_long_r;   // more than H_DISP pixels seen on this line
    logic          bad_r;         // current frame already known to be bad

    logic          href_fall_s;
    logic          fvld_rise_s;
    logic          fvld_fall_s;
    logic          in_frame_s;
    logic          active_s;
    logic          ovf_evt_s;
    logic          wr_s;
    logic [XW-1:0] x_after_s;
    logic          long_after_s;
    logic          line_end_s;
    logic          line_err_evt_s;
    logic          extra_line_s;
    logic [YW-1:0] y_after_s;
    logic          bad_after_s;
    logic          frame_end_s;
    logic          frame_good_s;

    // Edge detection, pixel counting and line/frame verdicts for this cycle.
    // A pixel arriving with the HREF fall is counted before the line check,
    // and the line check feeds the frame verdict of the same cycle.
    always_comb begin
        href_fall_s  = href_r & ~iHREF;
        fvld_rise_s  = ~fvld_r & iFRAME_VLD;
        fvld_fall_s  = fvld_r & ~iFRAME_VLD;
        in_frame_s   = (state_r == ACTIVE) || (state_r == DROP);
        active_s     = (state_r == ACTIVE);
        ovf_evt_s    = active_s & iPIX_VLD & wr.iWR_FULL;
        wr_s         = active_s & iPIX_VLD & ~wr.iWR_FULL &
                       (x_cnt_r < X_MAX) & (y_cnt_r < Y_MAX);
        x_after_s    = x_cnt_r;
        long_after_s = line_long_r;
        if (in_frame_s && iPIX_VLD) begin
            if (x_cnt_r == X_MAX) begin
                long_after_s = 1'b1;
            end else begin
                x_after_s = x_cnt_r + XW'(1);
            end
        end else begin
            x_after_s = x_cnt_r;
        end
        line_end_s     = in_frame_s & href_fall_s;
        line_err_evt_s = line_end_s & ((x_after_s != X_MAX) | long_after_s);
        extra_line_s   = line_end_s & (y_cnt_r == Y_MAX);
        if (line_end_s && (y_cnt_r != Y_MAX)) begin
            y_after_s = y_cnt_r + YW'(1);
        end else begin
            y_after_s = y_cnt_r;
        end
        bad_after_s  = bad_r | line_err_evt_s | ovf_evt_s | extra_line_s;
        frame_end_s  = in_frame_s & fvld_fall_s;
        frame_good_s = (y_after_s == Y_MAX) & ~bad_after_s;
    end

    // Frame FSM, counters, FIFO write port and status outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r     <= IDLE;
            href_r      <= 1'b0;
            fvld_r      <= 1'b0;
            x_cnt_r     <= {XW{1'b0}};
            y_cnt_r     <= {YW{1'b0}};
            line_long_r <= 1'b0;
            bad_r       <= 1'b0;
            wr.oWR_EN   <= 1'b0;
            wr.oWR_DATA <= {DW{1'b0}};
            wr.oWR_LOAD <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oLINE_ERR   <= 1'b0;
            oOVF        <= 1'b0;
        end else begin
            href_r      <= iHREF;
            fvld_r      <= iFRAME_VLD;
            wr.oWR_EN   <= wr_s;
            wr.oWR_LOAD <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            if (wr_s) begin
                wr.oWR_DATA <= iPIX_DATA;
            end
            // A new error beats a clear in the same cycle
            if (line_err_evt_s) begin
                oLINE_ERR <= 1'b1;
            end else if (iERR_CLR) begin
                oLINE_ERR <= 1'b0;
            end
            if (ovf_evt_s) begin
                oOVF <= 1'b1;
            end else if (iERR_CLR) begin
                oOVF <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    // Never start mid-frame: wait for vertical blank first
                    if (!iFRAME_VLD) begin
                        state_r <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (fvld_rise_s) begin
                        state_r     <= ACTIVE;
                        wr.oWR_LOAD <= 1'b1;
                        x_cnt_r     <= {XW{1'b0}};
                        y_cnt_r     <= {YW{1'b0}};
                        line_long_r <= 1'b0;
                        bad_r       <= 1'b0;
                    end
                end
                ACTIVE, DROP: begin
                    x_cnt_r     <= line_end_s ? {XW{1'b0}} : x_after_s;
                    line_long_r <= line_end_s ? 1'b0 : long_after_s;
                    y_cnt_r     <= y_after_s;
                    bad_r       <= bad_after_s;
                    if (frame_end_s) begin
                        state_r <= WAIT_SOF;
                        if (frame_good_s) begin
                            oFRAME_DONE <= 1'b1;
                        end else begin
                            oFRAME_ERR <= 1'b1;
                        end
                    end else if (ovf_evt_s) begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef CMOS_FPS_EN
    cmos_fps_meter #(
        .CLK_HZ (CLK_HZ)
    ) u_fps_meter (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iFRAME_DONE (oFRAME_DONE),
        .oFPS        (oFPS)
    );
`else
    assign oFPS = 8'd0;
    // CLK_HZ only sizes the FPS window; without the meter nothing is built
    if (CLK_HZ > 0) begin : g_no_fps_meter
    end
`endif

endmodule

// File: tb/tb_cmos_frame_writer.sv
// Self-checking bench for cmos_frame_writer (H_DISP=8, V_DISP=4).
// A frame-level model (pixel/line indices as plain integers) predicts every
// output one cycle after the inputs are driven; a negedge process compares.
module tb_cmos_frame_writer;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int DW = 16;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic [DW-1:0] iPIX_DATA = 16'h0000;
    logic          iPIX_VLD = 1'b0;
    logic          iHREF = 1'b0;
    logic          iFRAME_VLD = 1'b0;
    logic          iERR_CLR = 1'b0;
    logic          oFRAME_DONE, oFRAME_ERR, oLINE_ERR, oOVF;
    logic [7:0]    oFPS;

    cmos_frame_writer_if #(.DW(DW)) wr_if ();

    cmos_frame_writer #(
        .H_DISP (H), .V_DISP (V), .DW (DW), .CLK_HZ (1000)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iPIX_DATA   (iPIX_DATA),
        .iPIX_VLD    (iPIX_VLD),
        .iHREF       (iHREF),
        .iFRAME_VLD  (iFRAME_VLD),
        .iERR_CLR    (iERR_CLR),
        .wr          (wr_if),
        .oFRAME_DONE (oFRAME_DONE),
        .oFRAME_ERR  (oFRAME_ERR),
        .oLINE_ERR   (oLINE_ERR),
        .oOVF        (oOVF),
        .oFPS        (oFPS)
    );

    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_bad = 0;

    // expected outputs (valid after the posedge that consumed the inputs)
    logic        e_en = 1'b0, e_load = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic        e_lerr = 1'b0, e_ovf = 1'b0;
    logic [15:0] e_data = 16'h0000;

    // frame-level model state
    bit m_synced = 1'b0, m_in_frame = 1'b0, m_drop = 1'b0, m_bad = 1'b0;
    int m_pix = 0, m_line = 0;
    bit p_href = 1'b0, p_fvld = 1'b0;
    int fr_id = 0;
    int cyc_n = 0;

    // tallies of what the DUT actually produced
    int          t_wr = 0, t_load = 0, t_done = 0, t_err = 0;
    logic [15:0] t_first = 16'h0000, t_last = 16'h0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, plus output tallies
    always @(negedge iCLK) begin
        check("wr_en", 32'(wr_if.oWR_EN), 32'(e_en));
        if (e_en) check("wr_data", 32'(wr_if.oWR_DATA), 32'(e_data));
        check("wr_load", 32'(wr_if.oWR_LOAD), 32'(e_load));
        check("frame_done", 32'(oFRAME_DONE), 32'(e_done));
        check("frame_err", 32'(oFRAME_ERR), 32'(e_err));
        check("line_err", 32'(oLINE_ERR), 32'(e_lerr));
        check("ovf", 32'(oOVF), 32'(e_ovf));
`ifndef CMOS_FPS_EN
        check("fps_tied", 32'(oFPS), 32'd0);
`endif
        if (wr_if.oWR_EN === 1'b1) begin
            if (t_wr == 0) t_first = wr_if.oWR_DATA;
            t_last = wr_if.oWR_DATA;
            t_wr++;
        end
        if (wr_if.oWR_LOAD === 1'b1) t_load++;
        if (oFRAME_DONE === 1'b1) t_done++;
        if (oFRAME_ERR === 1'b1) t_err++;
    end

    task automatic clr_tally();
        t_wr = 0; t_load = 0; t_done = 0; t_err = 0;
    endtask

    // drive one cycle and predict the outputs that follow it
    task automatic cyc(input bit fv, input bit hr, input bit pv, input logic [15:0] d,
                       input bit full, input bit clr);
        bit n_en, n_load, n_done, n_err, lerr_evt, ovf_evt;
        logic [15:0] n_data;
        bit rise, fall, hfall;
        iFRAME_VLD = fv; iHREF = hr; iPIX_VLD = pv; iPIX_DATA = d;
        wr_if.iWR_FULL = full; iERR_CLR = clr;
        n_en = 1'b0; n_load = 1'b0; n_done = 1'b0; n_err = 1'b0;
        lerr_evt = 1'b0; ovf_evt = 1'b0; n_data = e_data;
        rise = fv && !p_fvld; fall = !fv && p_fvld; hfall = !hr && p_href;
        if (m_in_frame) begin
            if (pv) begin
                if (!m_drop && full) begin
                    ovf_evt = 1'b1; m_drop = 1'b1; m_bad = 1'b1;
                end else if (!m_drop && m_line < V && m_pix < H) begin
                    n_en = 1'b1; n_data = d;
                end
                m_pix++;
            end
            if (hfall) begin
                if (m_pix != H) begin lerr_evt = 1'b1; m_bad = 1'b1; end
                if (m_line >= V) m_bad = 1'b1;
                m_line++; m_pix = 0;
            end
            if (fall) begin
                if (m_line == V && !m_bad) n_done = 1'b1; else n_err = 1'b1;
                m_in_frame = 1'b0;
            end
        end else if (rise && m_synced) begin
            m_in_frame = 1'b1; m_drop = 1'b0; m_bad = 1'b0;
            m_pix = 0; m_line = 0; n_load = 1'b1;
        end
        if (!fv) m_synced = 1'b1;
        @(posedge iCLK); #1;
        cyc_n++;
        e_en = n_en; e_data = n_data; e_load = n_load; e_done = n_done; e_err = n_err;
        e_lerr = lerr_evt ? 1'b1 : (clr ? 1'b0 : e_lerr);
        e_ovf  = ovf_evt  ? 1'b1 : (clr ? 1'b0 : e_ovf);
        p_fvld = fv; p_href = hr;
    endtask

    task automatic do_reset(input bit fv, input bit hr);
        iRST_N = 1'b0;
        iFRAME_VLD = fv; iHREF = hr; iPIX_VLD = 1'b0; wr_if.iWR_FULL = 1'b0; iERR_CLR = 1'b0;
        e_en = 1'b0; e_load = 1'b0; e_done = 1'b0; e_err = 1'b0; e_lerr = 1'b0; e_ovf = 1'b0;
        m_synced = 1'b0; m_in_frame = 1'b0; p_fvld = 1'b0; p_href = 1'b0;
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;
    endtask

    function automatic logic [15:0] pix(input int l, input int p);
        return 16'((fr_id << 8) + (l << 4) + p);
    endfunction

    // one frame: nl lines, line sl has slen pixels, FIFO full on pixel full_at,
    // coinc: last pixel rides the HREF fall, eofc: frame ends on the last line end
    task automatic frame(input int nl, input int sl, input int slen, input int full_at,
                         input bit coinc, input bit eofc, input int clr_line);
        int g, len;
        bit last_line, fv_end;
        g = 0; fr_id++;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int l = 0; l < nl; l++) begin
            len = (l == sl) ? slen : H;
            last_line = (l == nl - 1);
            for (int p = 0; p < len; p++) begin
                fv_end = coinc && eofc && last_line && (p == len - 1);
                cyc(!fv_end, !(coinc && (p == len - 1)), 1'b1, pix(l, p), g == full_at, 1'b0);
                g++;
            end
            if (!coinc) cyc(!(eofc && last_line), 1'b0, 1'b0, 16'h0, 1'b0, l == clr_line);
            if (!last_line) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        end
        if (!eofc) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit clr);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, clr);
    endtask

    initial begin
        wr_if.iWR_FULL = 1'b0;
        do_reset(1'b0, 1'b0);
        idle(1'b0); idle(1'b0);

        // good 4x8 frame
        clr_tally();
        frame(4, -1, 0, -1, 1'b0, 1'b0, -1);
        check("good_writes", 32'(t_wr), 32'd32);
        check("good_loads", 32'(t_load), 32'd1);
        check("good_done", 32'(t_done), 32'd1);
        check("good_err", 32'(t_err), 32'd0);
        check("good_first", 32'(t_first), 32'h0100);
        check("good_last", 32'(t_last), 32'h0137);

        // reset released mid-frame: nothing written until a fresh SOF
        fr_id++;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int p = 0; p < 12; p++) cyc(1'b1, 1'b1, 1'b1, pix(0, p), 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        clr_tally();
        for (int p = 0; p < 20; p++) cyc(1'b1, (p % 10) != 9, 1'b1, pix(1, p), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);
        check("midrst_writes", 32'(t_wr), 32'd0);
        check("midrst_pulses", 32'(t_load + t_done + t_err), 32'd0);
        clr_tally();
        frame(4, -1, 0, -1, 1'b0, 1'b0, -1);
        check("after_rst_writes", 32'(t_wr), 32'd32);
        check("after_rst_done", 32'(t_done), 32'd1);

        // short line (7 pixels on line index 1)
        clr_tally();
        frame(4, 1, 7, -1, 1'b0, 1'b0, -1);
        check("short_writes", 32'(t_wr), 32'd31);
        check("short_err", 32'(t_err), 32'd1);
        check("short_done", 32'(t_done), 32'd0);
        check("short_lerr", 32'(oLINE_ERR), 32'd1);
        idle(1'b1);
        check("lerr_cleared", 32'(oLINE_ERR), 32'd0);

        // clear coincident with a new line error: error wins
        frame(4, 2, 7, -1, 1'b0, 1'b0, 2);
        check("clr_vs_err", 32'(oLINE_ERR), 32'd1);
        idle(1'b1);

        // FIFO full on the 10th pixel
        clr_tally();
        frame(4, -1, 0, 9, 1'b0, 1'b0, -1);
        check("ovf_writes", 32'(t_wr), 32'd9);
        check("ovf_flag", 32'(oOVF), 32'd1);
        check("ovf_err", 32'(t_err), 32'd1);
        idle(1'b1);
        check("ovf_cleared", 32'(oOVF), 32'd0);
        clr_tally();
        frame(4, -1, 0, -1, 1'b0, 1'b0, -1);
        check("post_ovf_writes", 32'(t_wr), 32'd32);
        check("post_ovf_done", 32'(t_done), 32'd1);

        // long line (10 pixels on line 0): only 8 written
        clr_tally();
        frame(4, 0, 10, -1, 1'b0, 1'b0, -1);
        check("long_writes", 32'(t_wr), 32'd32);
        check("long_lerr", 32'(oLINE_ERR), 32'd1);
        check("long_err", 32'(t_err), 32'd1);
        idle(1'b1);

        // five lines: extra line not written, frame bad
        clr_tally();
        frame(5, -1, 0, -1, 1'b0, 1'b0, -1);
        check("five_writes", 32'(t_wr), 32'd32);
        check("five_err", 32'(t_err), 32'd1);
        check("five_done", 32'(t_done), 32'd0);
        check("five_lerr", 32'(oLINE_ERR), 32'd0);

        // three lines: short frame
        clr_tally();
        frame(3, -1, 0, -1, 1'b0, 1'b0, -1);
        check("three_writes", 32'(t_wr), 32'd24);
        check("three_err", 32'(t_err), 32'd1);

        // last pixel on HREF fall and frame end on the final line end
        clr_tally();
        frame(4, -1, 0, -1, 1'b1, 1'b1, -1);
        check("coinc_writes", 32'(t_wr), 32'd32);
        check("coinc_done", 32'(t_done), 32'd1);
        check("coinc_last", 32'(t_last), 32'(pix(3, 7)));

`ifdef CMOS_FPS_EN
        // one good frame every 100 cycles against a 1000-cycle window
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            int start;
            start = cyc_n;
            idle(1'b0);
            frame(4, -1, 0, -1, 1'b0, 1'b0, -1);
            while (cyc_n - start < 100) idle(1'b0);
        end
        check("fps_value", 32'(oFPS), 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
